wb_regfile_scoreboard: RTL and testbench
========================================

Name: wb_regfile_scoreboard

Overview:
- 16-bit general-purpose register file. It is the consumer end of the write-back path: it takes the selected write-back result and commits it to the addressed register.
- Provides two read ports to decode, with same-cycle write-to-read bypass.
- Keeps a per-register outstanding-write scoreboard so decode can stall on RAW hazards.
- Sits between the write-back select stage (write side) and the decode/operand-fetch stage (read and issue side).

Parameters:
- DATA_W, 16, register and write-back data width
- NUM_REGS, 16, number of architectural registers
- ADDR_W, 4, register address width (log2 NUM_REGS)
- CNT_W, 2, width of each per-register pending-write counter (max 2^CNT_W-1 in-flight writers)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- wb_we  input  1  write-back commit strobe
- wb_addr  input  ADDR_W  destination register of the commit
- wb_data  input  DATA_W  write-back result (output of the write-back select stage)
- ra1  input  ADDR_W  read port 1 address
- ra2  input  ADDR_W  read port 2 address
- rd1  output  DATA_W  read port 1 data
- rd2  output  DATA_W  read port 2 data
- iss_valid  input  1  decode issues an instruction that will write a register
- iss_rd  input  ADDR_W  destination register of the issued instruction
- busy1  output  1  ra1 has an outstanding write not satisfied this cycle
- busy2  output  1  ra2 has an outstanding write not satisfied this cycle
- ovf_err  output  1  sticky: issue attempted on a saturated counter
- unf_err  output  1  sticky: commit to a register with zero pending count

Behaviour:
- Reset (async, immediate on rst=1):
  - all registers = 0, all pending counters = 0
  - ovf_err = 0, unf_err = 0
  - rd1/rd2 therefore read 0; busy1/busy2 = 0
  - Reset mid-operation discards all pending state; no commit occurs in a cycle where rst is high.
- Register 0:
  - hardwired zero; reads always return 0, never busy.
  - wb_we to addr 0 ignored, with no counter or error effect.
  - iss_valid with iss_rd=0 ignored.
- Write:
  - on rising edge with wb_we=1 and wb_addr!=0, reg[wb_addr] <= wb_data.
  - 1-cycle write latency to storage.
- Read:
  - combinational, 0-cycle.
  - rdN = 0 if raN=0.
  - else rdN = wb_data if wb_we and wb_addr==raN (bypass).
  - else rdN = reg[raN].
  - Both ports may address the same register.
- Pending counter cnt[r], per rising edge, for r!=0:
  - inc = iss_valid && iss_rd==r; dec = wb_we && wb_addr==r.
  - inc && dec: cnt unchanged.
  - inc only: if cnt==max, cnt holds and ovf_err <= 1; else cnt+1.
  - dec only: if cnt==0, cnt holds at 0 and unf_err <= 1 (data is still written); else cnt-1.
- Busy:
  - busyN = (raN!=0) && cnt[raN]!=0 && !(wb_we && wb_addr==raN && cnt[raN]==1).
  - A commit of the last outstanding writer clears busy in the same cycle, consistent with the bypass.
  - Busy never reflects the same-cycle issue; the issuing instruction's own operands are not blocked by itself.
- Error flags: sticky until rst.

Optional Feature:
- REGFILE_DEBUG_PORT_EN defined:
  - adds input dbg_addr (ADDR_W) and output dbg_data (DATA_W).
  - dbg_data = reg[dbg_addr], combinational, no bypass; reg 0 reads 0.
  - Intended for display/debug readout.
- Undefined: ports absent; no other behaviour change.

Test Plan:
- Reset, then read ra1=5, ra2=0 -> rd1=0, rd2=0, busy1=busy2=0, ovf_err=unf_err=0.
- Issue iss_rd=3; next cycle ra1=3 -> busy1=1. Commit wb_addr=3, wb_data=0x1234 with ra1=3 in the same cycle -> rd1=0x1234 (bypass), busy1=0. Next cycle rd1=0x1234 from storage.
- Issue iss_rd=4 twice, then commit 0x00AA to r4 -> busy on ra=4 stays 1 (cnt 2->1). Second commit 0x00BB -> busy 0 in that cycle, rd=0x00BB.
- Same cycle: iss_valid with iss_rd=6, and wb_we with wb_addr=6, wb_data=0x5555, when cnt[6]=1 -> cnt stays 1, busy stays 1 next cycle, reg6=0x5555.
- Issue r7 four times with CNT_W=2 -> ovf_err=1 after the 4th issue, cnt[7]=3. Commit to r8 with cnt 0 -> unf_err=1, reg8 written.
- Write 0xFFFF to r0 -> rd=0, unf_err unchanged. Assert rst mid-stream with cnt[3]=2 -> counters, registers and errors clear immediately.

Source files
------------

// File: rtl/wb_regfile_if.sv
// wb_regfile_if
//    Bundles the write-back commit, decode read and issue signals of the
//    register file / scoreboard.
//    master : write-back select + decode side (drives commits, reads, issues)
//    slave  : register file (returns read data, busy flags, error flags)
//    Signals:
//       wb_we, wb_addr, wb_data  write-back commit
//       ra1, ra2 / rd1, rd2      two read ports
//       iss_valid, iss_rd        issue of a register-writing instruction
//       busy1, busy2             RAW hazard indication for ra1/ra2
//       ovf_err, unf_err         sticky scoreboard error flags
interface wb_regfile_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              wb_we;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [ADDR_W-1:0] ra1;
   logic [ADDR_W-1:0] ra2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              iss_valid;
   logic [ADDR_W-1:0] iss_rd;
   logic              busy1;
   logic              busy2;
   logic              ovf_err;
   logic              unf_err;

   modport master (
      output wb_we, wb_addr, wb_data, ra1, ra2, iss_valid, iss_rd,
      input  rd1, rd2, busy1, busy2, ovf_err, unf_err
   );

   modport slave (
      input  wb_we, wb_addr, wb_data, ra1, ra2, iss_valid, iss_rd,
      output rd1, rd2, busy1, busy2, ovf_err, unf_err
   );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// wb_regfile_scoreboard
//    16-bit general-purpose register file at the end of the write-back path,
//    with two combinational read ports (write-to-read bypass) and a
//    per-register pending-write counter scoreboard for RAW stall detection.
//    Register 0 is hardwired to zero and never tracked.
//    Ports:
//       clk   single clock, rising edge
//       rst   asynchronous active-high reset (clears registers, counters, flags)
//       bus   wb_regfile_if.slave (commit, reads, issue, busy, error flags)
//    Optional build macro REGFILE_DEBUG_PORT_EN adds:
//       dbg_addr  input  debug readout address
//       dbg_data  output storage contents of dbg_addr (no bypass)
module wb_regfile_scoreboard #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 4,
   parameter int CNT_W    = 2
) (
   input  logic              clk,
   input  logic              rst,
`ifdef REGFILE_DEBUG_PORT_EN
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
`endif
   wb_regfile_if.slave       bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] regs_reg [NUM_REGS];
   logic [CNT_W-1:0]  cnt_reg  [NUM_REGS];
   logic              ovf_reg;
   logic              unf_reg;

   // Per-register event vectors; bit 0 stays zero so r0 is never touched.
   logic [NUM_REGS-1:0] inc_vec;
   logic [NUM_REGS-1:0] dec_vec;
   logic [NUM_REGS-1:0] ovf_vec;
   logic [NUM_REGS-1:0] unf_vec;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_evt
         if (gi == 0) begin : g_r0
            assign inc_vec[gi] = 1'b0;
            assign dec_vec[gi] = 1'b0;
            assign ovf_vec[gi] = 1'b0;
            assign unf_vec[gi] = 1'b0;
         end else begin : g_rn
            assign inc_vec[gi] = bus.iss_valid && (bus.iss_rd == ADDR_W'(gi));
            assign dec_vec[gi] = bus.wb_we && (bus.wb_addr == ADDR_W'(gi));
            // Simultaneous issue and commit cancel, so neither can err.
            assign ovf_vec[gi] = inc_vec[gi] && !dec_vec[gi] && (cnt_reg[gi] == CNT_MAX);
            assign unf_vec[gi] = dec_vec[gi] && !inc_vec[gi] && (cnt_reg[gi] == '0);
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_reg[r] <= '0;
            cnt_reg[r]  <= '0;
         end
         ovf_reg <= 1'b0;
         unf_reg <= 1'b0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            // Data is committed even when the counter underflows.
            if (dec_vec[r])
               regs_reg[r] <= bus.wb_data;
            if (inc_vec[r] && !dec_vec[r] && cnt_reg[r] != CNT_MAX)
               cnt_reg[r] <= cnt_reg[r] + CNT_ONE;
            else if (dec_vec[r] && !inc_vec[r] && cnt_reg[r] != '0)
               cnt_reg[r] <= cnt_reg[r] - CNT_ONE;
         end
         ovf_reg <= ovf_reg | (|ovf_vec);
         unf_reg <= unf_reg | (|unf_vec);
      end
   end

   // Read ports: r0 reads zero, a same-cycle commit bypasses storage.
   // Busy drops in the cycle the last outstanding writer commits, matching
   // the bypassed data.
   always_comb begin
      bus.rd1   = '0;
      bus.rd2   = '0;
      bus.busy1 = 1'b0;
      bus.busy2 = 1'b0;
      if (bus.ra1 != '0) begin
         if (bus.wb_we && bus.wb_addr == bus.ra1)
            bus.rd1 = bus.wb_data;
         else
            bus.rd1 = regs_reg[bus.ra1];
         bus.busy1 = (cnt_reg[bus.ra1] != '0) &&
                     !(bus.wb_we && bus.wb_addr == bus.ra1 && cnt_reg[bus.ra1] == CNT_ONE);
      end
      if (bus.ra2 != '0) begin
         if (bus.wb_we && bus.wb_addr == bus.ra2)
            bus.rd2 = bus.wb_data;
         else
            bus.rd2 = regs_reg[bus.ra2];
         bus.busy2 = (cnt_reg[bus.ra2] != '0) &&
                     !(bus.wb_we && bus.wb_addr == bus.ra2 && cnt_reg[bus.ra2] == CNT_ONE);
      end
   end

   assign bus.ovf_err = ovf_reg;
   assign bus.unf_err = unf_reg;

`ifdef REGFILE_DEBUG_PORT_EN
   assign dbg_data = (dbg_addr == '0) ? '0 : regs_reg[dbg_addr];
`endif

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
module tb_wb_regfile_scoreboard;

   logic clk;
   logic rst;

   wb_regfile_if #(.DATA_W(16), .ADDR_W(4)) bus ();

   wb_regfile_scoreboard #(
      .DATA_W(16), .NUM_REGS(16), .ADDR_W(4), .CNT_W(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: register values, outstanding-writer counts, sticky flags.
   int unsigned m_reg [16];
   int          m_cnt [16];
   bit          m_ovf;
   bit          m_unf;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 16; r++) begin
         m_reg[r] = 0;
         m_cnt[r] = 0;
      end
      m_ovf = 0;
      m_unf = 0;
   endtask

   function automatic int unsigned exp_rd(input int a, input bit we, input int wa, input int unsigned wd);
      if (a == 0)             return 0;
      if (we && wa == a)      return wd;
      return m_reg[a];
   endfunction

   // Writers still outstanding after this cycle's commit.
   function automatic bit exp_busy(input int a, input bit we, input int wa);
      int remaining;
      if (a == 0) return 0;
      remaining = m_cnt[a] - ((we && wa == a) ? 1 : 0);
      return remaining > 0;
   endfunction

   // One clock cycle: apply inputs, check all outputs against the model,
   // then clock and advance the model.
   task automatic step(input bit we, input int wa, input int unsigned wd,
                       input int a1, input int a2, input bit iv, input int ir);
      @(negedge clk);
      bus.wb_we     = we;
      bus.wb_addr   = 4'(wa);
      bus.wb_data   = 16'(wd);
      bus.ra1       = 4'(a1);
      bus.ra2       = 4'(a2);
      bus.iss_valid = iv;
      bus.iss_rd    = 4'(ir);
      #1;
      check_val("rd1",  32'(bus.rd1),   32'(exp_rd(a1, we, wa, wd)));
      check_val("rd2",  32'(bus.rd2),   32'(exp_rd(a2, we, wa, wd)));
      check_val("busy1", 32'(bus.busy1), 32'(exp_busy(a1, we, wa)));
      check_val("busy2", 32'(bus.busy2), 32'(exp_busy(a2, we, wa)));
      check_val("ovf",  32'(bus.ovf_err), 32'(m_ovf));
      check_val("unf",  32'(bus.unf_err), 32'(m_unf));
      $display("txn we=%0d wa=%0d wd=%04h ra1=%0d ra2=%0d iss=%0d ird=%0d rd1=%04h rd2=%04h b1=%0d b2=%0d",
               we, wa, wd, a1, a2, iv, ir, bus.rd1, bus.rd2, bus.busy1, bus.busy2);
      @(posedge clk);
      if (we && wa != 0) m_reg[wa] = wd & 16'hFFFF;
      for (int r = 1; r < 16; r++) begin
         bit inc, dec;
         inc = iv && ir == r;
         dec = we && wa == r;
         if (inc && !dec) begin
            if (m_cnt[r] == 3) m_ovf = 1; else m_cnt[r]++;
         end else if (dec && !inc) begin
            if (m_cnt[r] == 0) m_unf = 1; else m_cnt[r]--;
         end
      end
   endtask

   task automatic idle(input int a1, input int a2);
      step(0, 0, 0, a1, a2, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
      bus.ra1 = 0; bus.ra2 = 0; bus.iss_valid = 0; bus.iss_rd = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      idle(5, 0);
      check_val("reset_rd1", 32'(bus.rd1), 32'h0);

      // Single issue / commit on r3 with bypass
      step(0, 0, 0, 3, 0, 1, 3);
      idle(3, 0);
      check_val("r3_busy", 32'(bus.busy1), 32'h1);
      step(1, 3, 16'h1234, 3, 0, 0, 0);
      check_val("r3_bypass", 32'(bus.rd1), 32'h1234);
      check_val("r3_busy_clr", 32'(bus.busy1), 32'h0);
      idle(3, 3);
      check_val("r3_stored", 32'(bus.rd2), 32'h1234);

      // Two writers on r4
      step(0, 0, 0, 0, 0, 1, 4);
      step(0, 0, 0, 0, 0, 1, 4);
      step(1, 4, 16'h00AA, 4, 0, 0, 0);
      check_val("r4_busy_first", 32'(bus.busy1), 32'h1);
      step(1, 4, 16'h00BB, 4, 4, 0, 0);
      check_val("r4_busy_last", 32'(bus.busy1), 32'h0);
      check_val("r4_rd_last", 32'(bus.rd2), 32'h00BB);

      // Simultaneous issue and commit on r6 with one outstanding writer
      step(0, 0, 0, 0, 0, 1, 6);
      step(1, 6, 16'h5555, 0, 0, 1, 6);
      idle(6, 0);
      check_val("r6_busy_hold", 32'(bus.busy1), 32'h1);
      check_val("r6_data", 32'(bus.rd1), 32'h5555);

      // Saturate r7, underflow r8
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1, 7);
      idle(7, 0);
      check_val("ovf_set", 32'(bus.ovf_err), 32'h1);
      step(1, 8, 16'hBEEF, 0, 0, 0, 0);
      idle(8, 0);
      check_val("unf_set", 32'(bus.unf_err), 32'h1);
      check_val("r8_data", 32'(bus.rd1), 32'hBEEF);

      // r0 writes and issues ignored
      step(1, 0, 16'hFFFF, 0, 0, 1, 0);
      idle(0, 0);

      // Asynchronous reset mid-stream with cnt[3]=2
      step(0, 0, 0, 0, 0, 1, 3);
      step(0, 0, 0, 0, 0, 1, 3);
      @(negedge clk);
      bus.wb_we = 0; bus.iss_valid = 0;
      bus.ra1 = 4'd3; bus.ra2 = 4'd8;
      #2;
      rst = 1'b1;
      #1;
      check_val("rst_busy1", 32'(bus.busy1), 32'h0);
      check_val("rst_rd2", 32'(bus.rd2), 32'h0);
      check_val("rst_ovf", 32'(bus.ovf_err), 32'h0);
      check_val("rst_unf", 32'(bus.unf_err), 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit          we, iv;
         int          wa, a1, a2, ir;
         int unsigned wd;
         we = ($urandom_range(0, 9) < 4);
         iv = ($urandom_range(0, 9) < 4);
         wa = $urandom_range(0, 15);
         ir = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
         a1 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 15);
         a2 = $urandom_range(0, 15);
         wd = $urandom_range(0, 16'hFFFF);
         step(we, wa, wd, a1, a2, iv, ir);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
